// File: rtl/multi_channel_pooling_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | multi_channel_pooling_engine                                           |
// | Streaming 2x2 stride-2 max/average pooling over CHANNELS parallel lanes |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module multi_channel_pooling_engine #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 1,
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  localparam int c_PXW   = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1,
  localparam int c_PYW   = (HEIGHT / 2 > 1) ? $clog2(HEIGHT / 2) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic                         in_sof,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic                         mode,
  output logic [CHANNELS*DATA_W-1:0]   pool_out,
  output logic                         pool_valid,
  output logic [c_PXW-1:0]             pool_x,
  output logic [c_PYW-1:0]             pool_y,
  output logic                         pool_eof
);

  localparam int c_XW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_YW       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int c_PW       = DATA_W + 1;
  localparam int c_LB_DEPTH = WIDTH / 2;
  localparam logic [c_XW-1:0]  c_X_MAX   = c_XW'(WIDTH - 1);
  localparam logic [c_YW-1:0]  c_Y_MAX   = c_YW'(HEIGHT - 1);
  localparam logic [c_PXW-1:0] c_PX_LAST = c_PXW'(WIDTH / 2 - 1);
  localparam logic [c_PYW-1:0] c_PY_LAST = c_PYW'(HEIGHT / 2 - 1);

  logic [c_XW-1:0]  r_x, w_x;
  logic [c_YW-1:0]  r_y, w_y;
  logic             r_mode, w_mode;
  logic             w_sof;
  logic             w_col_ok, w_row_ok;
  logic             w_pair_en, w_out_en;
  logic [c_PXW-1:0] w_addr;
  logic [c_PYW-1:0] w_yaddr;
  logic             w_eof;

  logic [CHANNELS*DATA_W-1:0] r_h;
  logic [CHANNELS*c_PW-1:0]   w_pair_all;
  logic [CHANNELS*c_PW-1:0]   w_lb_rd;
  logic [CHANNELS*DATA_W-1:0] w_res_all;
  logic [CHANNELS*c_PW-1:0]   r_lb [c_LB_DEPTH];

  // An accepted sof pixel is treated as (0,0) with the freshly sampled mode.
  assign w_sof    = in_valid & in_sof;
  assign w_x      = w_sof ? '0 : r_x;
  assign w_y      = w_sof ? '0 : r_y;
  assign w_mode   = w_sof ? mode : r_mode;

  assign w_col_ok  = !((WIDTH % 2 == 1) && (w_x == c_X_MAX));
  assign w_row_ok  = !((HEIGHT % 2 == 1) && (w_y == c_Y_MAX));
  assign w_pair_en = in_valid & w_x[0];
  assign w_out_en  = w_pair_en & w_y[0];
  assign w_addr    = c_PXW'(w_x >> 1);
  assign w_yaddr   = c_PYW'(w_y >> 1);
  assign w_eof     = (w_addr == c_PX_LAST) && (w_yaddr == c_PY_LAST);
  assign w_lb_rd   = r_lb[w_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_mode <= 1'b0;
    end else if (in_valid) begin
      r_mode <= w_mode;
      if (w_x == c_X_MAX) begin
        r_x <= '0;
        r_y <= (w_y == c_Y_MAX) ? '0 : w_y + 1'b1;
      end else begin
        r_x <= w_x + 1'b1;
        r_y <= w_y;
      end
    end
  end

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [DATA_W-1:0] w_in, w_h, w_hmax, w_res;
      logic [c_PW-1:0]   w_pair, w_lbv, w_vmax;
      logic [DATA_W+1:0] w_sum;

      assign w_in   = in_data[c*DATA_W +: DATA_W];
      assign w_h    = r_h[c*DATA_W +: DATA_W];
      assign w_lbv  = w_lb_rd[c*c_PW +: c_PW];
      assign w_hmax = (w_h > w_in) ? w_h : w_in;
      assign w_pair = w_mode ? ({1'b0, w_h} + {1'b0, w_in}) : {1'b0, w_hmax};
      // Four-sample sum needs DATA_W+2 bits; dropping the low two bits floors the mean.
      assign w_sum  = {1'b0, w_lbv} + {1'b0, w_pair};
      assign w_vmax = (w_lbv > w_pair) ? w_lbv : w_pair;
      assign w_res  = w_mode ? DATA_W'(w_sum >> 2) : DATA_W'(w_vmax);

      assign w_pair_all[c*c_PW +: c_PW]   = w_pair;
      assign w_res_all[c*DATA_W +: DATA_W] = w_res;
    end
  endgenerate

  // Even rows deposit pair values; the following odd row consumes them.
  always_ff @(posedge clk) begin
    if (w_pair_en && !w_y[0] && w_row_ok) begin
      r_lb[w_addr] <= w_pair_all;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_h        <= '0;
      pool_out   <= '0;
      pool_valid <= 1'b0;
      pool_x     <= '0;
      pool_y     <= '0;
      pool_eof   <= 1'b0;
    end else begin
      pool_valid <= w_out_en;
      pool_eof   <= w_out_en & w_eof;
      if (in_valid && !w_x[0] && w_col_ok) begin
        r_h <= in_data;
      end
      if (w_out_en) begin
        pool_out <= w_res_all;
        pool_x   <= w_addr;
        pool_y   <= w_yaddr;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_pooling_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_multi_channel_pooling_engine                                        |
// | Two engines (4x4 and 5x5, 3 lanes) fed one shared stream vs a frame model|
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_multi_channel_pooling_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [23:0] in_data = '0;
  logic        mode = 1'b0;

  logic [23:0] out_a, out_b;
  logic        val_a, val_b, eof_a, eof_b;
  logic [0:0]  px_a, py_a, px_b, py_b;

  always #5 clk = ~clk;

  multi_channel_pooling_engine #(.DATA_W(8), .CHANNELS(3), .WIDTH(4), .HEIGHT(4)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .mode(mode), .pool_out(out_a), .pool_valid(val_a), .pool_x(px_a), .pool_y(py_a),
    .pool_eof(eof_a));

  multi_channel_pooling_engine #(.DATA_W(8), .CHANNELS(3), .WIDTH(5), .HEIGHT(5)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .mode(mode), .pool_out(out_b), .pool_valid(val_b), .pool_x(px_b), .pool_y(py_b),
    .pool_eof(eof_b));

  int n_cmp = 0;
  int n_bad = 0;

  // Frame model: every accepted pixel is stored at its raster position.
  int          mw [2] = '{4, 5};
  int          mh [2] = '{4, 5};
  logic [23:0] pix [2][5][5];
  int          bx [2], by [2];
  bit          mm [2];
  bit          ev [2], ee [2];
  logic [23:0] eo [2];
  int          ex [2], ey [2];

  logic [23:0] cap [$];
  int          strobes_b;

  logic [7:0] f1   [16] = '{10, 20, 30, 40, 50, 60, 70, 80, 15, 25, 35, 45, 55, 65, 75, 85};
  logic [7:0] f_tr [16] = '{1, 1, 9, 9, 1, 2, 9, 9, 0, 0, 0, 0, 0, 0, 0, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] win(input int d, input int x, input int y, input bit m);
    logic [23:0] r;
    int v [4];
    int mx;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      v[0] = int'(pix[d][y-1][x-1][c*8 +: 8]);
      v[1] = int'(pix[d][y-1][x][c*8 +: 8]);
      v[2] = int'(pix[d][y][x-1][c*8 +: 8]);
      v[3] = int'(pix[d][y][x][c*8 +: 8]);
      mx = v[0];
      for (int k = 1; k < 4; k++) if (v[k] > mx) mx = v[k];
      r[c*8 +: 8] = m ? 8'((v[0] + v[1] + v[2] + v[3]) / 4) : 8'(mx);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      bx[d] = 0; by[d] = 0; mm[d] = 1'b0;
    end
  endtask

  task automatic model_accept(input int d, input bit s, input logic [23:0] dat, input bit m);
    if (s) begin
      bx[d] = 0; by[d] = 0; mm[d] = m;
    end
    pix[d][by[d]][bx[d]] = dat;
    if ((bx[d] % 2 == 1) && (by[d] % 2 == 1) && (bx[d] < (mw[d] / 2) * 2) &&
        (by[d] < (mh[d] / 2) * 2)) begin
      ev[d] = 1'b1;
      eo[d] = win(d, bx[d], by[d], mm[d]);
      ex[d] = bx[d] / 2;
      ey[d] = by[d] / 2;
      ee[d] = (ex[d] == mw[d] / 2 - 1) && (ey[d] == mh[d] / 2 - 1);
    end
    bx[d]++;
    if (bx[d] == mw[d]) begin
      bx[d] = 0;
      by[d]++;
      if (by[d] == mh[d]) by[d] = 0;
    end
  endtask

  task automatic step(input bit v, input bit s, input logic [23:0] d, input bit m);
    in_valid = v; in_sof = s; in_data = d; mode = m;
    @(posedge clk);
    #1;
    ev[0] = 1'b0; ev[1] = 1'b0;
    if (v) for (int k = 0; k < 2; k++) model_accept(k, s, d, m);
    chk("a.valid", val_a, ev[0]);
    if (ev[0]) begin
      chk("a.data", out_a, eo[0]);
      chk("a.x", px_a, ex[0]);
      chk("a.y", py_a, ey[0]);
      chk("a.eof", eof_a, ee[0]);
    end
    chk("b.valid", val_b, ev[1]);
    if (ev[1]) begin
      chk("b.data", out_b, eo[1]);
      chk("b.x", px_b, ex[1]);
      chk("b.y", py_b, ey[1]);
      chk("b.eof", eof_b, ee[1]);
    end
    if (val_a) cap.push_back(out_a);
    if (val_b) strobes_b++;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  // Up to three idle cycles (with stray sof/mode activity) before each pixel.
  task automatic px(input logic [23:0] d, input bit s, input bit m, input int gap_pct);
    for (int g = 0; g < 3; g++) begin
      if (int'($urandom_range(99)) < gap_pct)
        step(1'b0, 1'($urandom_range(1)), 24'($urandom), 1'($urandom_range(1)));
    end
    step(1'b1, s, d, m);
  endtask

  task automatic frame4(input logic [7:0] v [16], input bit m, input int gap_pct,
                        input bit toggle);
    bit mk;
    for (int k = 0; k < 16; k++) begin
      mk = (k != 0 && toggle) ? 1'($urandom_range(1)) : m;
      px({8'($urandom), 8'($urandom), v[k]}, k == 0, mk, gap_pct);
    end
  endtask

  task automatic chk_cap(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    chk({tag, ".count"}, cap.size(), 4);
    if (cap.size() >= 4) begin
      chk({tag, ".v0"}, cap[0][7:0], e0);
      chk({tag, ".v1"}, cap[1][7:0], e1);
      chk({tag, ".v2"}, cap[2][7:0], e2);
      chk({tag, ".v3"}, cap[3][7:0], e3);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".a.valid"}, val_a, 0);
    chk({tag, ".a.out"}, out_a, 0);
    chk({tag, ".a.xy"}, {px_a, py_a}, 0);
    chk({tag, ".a.eof"}, eof_a, 0);
    chk({tag, ".b.valid"}, val_b, 0);
    chk({tag, ".b.out"}, out_b, 0);
    chk({tag, ".b.xy"}, {px_b, py_b}, 0);
    chk({tag, ".b.eof"}, eof_b, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    reset = 1'b1;
    model_reset();

    // 4x4 max frame on lane 0
    cap.delete();
    frame4(f1, 1'b0, 0, 1'b0);
    chk_cap("max4", 8'd60, 8'd80, 8'd65, 8'd85);

    // same frame, average mode, then floor check on 1,1,1,2
    cap.delete();
    frame4(f1, 1'b1, 0, 1'b0);
    chk_cap("avg4", 8'd35, 8'd55, 8'd40, 8'd60);
    cap.delete();
    frame4(f_tr, 1'b1, 0, 1'b0);
    chk("trunc.count", cap.size(), 4);
    if (cap.size() > 0) chk("trunc.v0", cap[0][7:0], 1);

    // valid gaps and mid-frame mode toggling
    cap.delete();
    frame4(f1, 1'b0, 40, 1'b1);
    chk_cap("gaps", 8'd60, 8'd80, 8'd65, 8'd85);

    // lane 2 saturated, average mode, then a back-to-back frame with no sof
    cap.delete();
    for (int k = 0; k < 32; k++)
      px({8'hFF, 8'($urandom), 8'($urandom)}, k == 0, (k == 0) ? 1'b1 : 1'b0, 0);
    chk("sat.count", cap.size(), 8);
    foreach (cap[i]) chk("sat.lane2", cap[i][23:16], 8'hFF);

    // 5x5 frame, then sof again at (3,1)
    strobes_b = 0;
    for (int k = 0; k < 25; k++)
      px(24'($urandom), k == 0, (k == 0) ? 1'($urandom_range(1)) : 1'b0, 0);
    chk("odd.count", strobes_b, 4);
    strobes_b = 0;
    for (int k = 0; k < 8; k++) px(24'($urandom), k == 0, 1'b0, 0);
    for (int k = 0; k < 25; k++) px(24'($urandom), k == 0, 1'b1, 10);
    chk("midsof.count", strobes_b, 5);

    // asynchronous reset while a strobe is being presented
    for (int k = 0; k < 6; k++) px({16'h0, f1[k]}, k == 0, 1'b0, 0);
    chk("rst.pre_valid", val_a, 1);
    #2 reset = 1'b0;
    #1;
    chk_idle("rst.async");
    model_reset();
    step(1'b0, 1'b0, 24'h0, 1'b0);
    step(1'b1, 1'b0, 24'h0, 1'b0);
    ev[0] = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 24'h0, 1'b0);
    step(1'b0, 1'b0, 24'h0, 1'b0);
    cap.delete();
    frame4(f1, 1'b0, 0, 1'b0);
    chk_cap("post_rst", 8'd60, 8'd80, 8'd65, 8'd85);

    // random frames with random modes, gaps and mid-frame mode noise
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 25; k++)
        px(24'($urandom), (k == 0) && (f % 3 != 2), 1'($urandom_range(1)), 25);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
